access_ctrl: RTL
================

# access_ctrl

Sequencing controller for the 2-bit code-compare machine. It latches a user code on a `go` strobe and drives it with the stored reference code into the compare datapath. It then issues a one-cycle enable, samples the datapath's match result and decides grant, deny or lockout. It owns the stored reference code and the failed-attempt counter. It sits between the user-input front end and the compare machine.

## Interface
- `GRANT_CYCLES`, default 10: cycles `grant` stays high after a match; must be ≥1.
- `LOCK_CYCLES`, default 50: cycles `locked` stays high after `MAX_TRIES` failures; must be ≥1.
- `MAX_TRIES`, default 3: consecutive failures that trigger lockout; range 1–3.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `go`  in  1  single-cycle request to check `code`.
- `code`  in  2  user code; sampled on `go` or on `prog`.
- `prog`  in  1  single-cycle request to overwrite the stored reference with `code`.
- `match`  in  1  compare result from the datapath; valid only in state WAIT.
- `en`  out  1  compare enable to the datapath.
- `b`  out  2  latched user code to the datapath.
- `v`  out  2  stored reference code to the datapath.
- `grant`  out  1  access granted.
- `deny`  out  1  one-cycle failure indication.
- `locked`  out  1  lockout active.
- `tries`  out  2  consecutive failed attempts.
- `busy`  out  1  high in every state except IDLE.

## Operation
- All outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs.
- Reset (`rst_n`=0 at an edge) puts the block in IDLE. It also sets `b`=00, `v`=00, `tries`=0, clears the counter, and drives `en`, `grant`, `deny`, `locked` and `busy` to 0.
- States are IDLE, CHECK, WAIT, GRANT, DENY and LOCK.
- IDLE:
  - `go`=1: latch `b`←`code` and go to CHECK.
  - `prog` is ignored.
- CHECK:
  - `en`=1 for exactly this one cycle.
  - Always go to WAIT next.
- WAIT: sample `match`.
  - `match`=1: set `tries`←0, load counter ← `GRANT_CYCLES`−1, go to GRANT.
  - `match`=0 and `tries`+1 < `MAX_TRIES`: set `tries`←`tries`+1, go to DENY.
  - `match`=0 and `tries`+1 = `MAX_TRIES`: set `tries`←`MAX_TRIES`, load counter ← `LOCK_CYCLES`−1, go to LOCK.
- GRANT:
  - `grant`=1.
  - `prog`=1: `v`←`code` on that edge; the state stays GRANT and the counter is unaffected.
  - Counter = 0: go to IDLE. Otherwise decrement.
- DENY:
  - `deny`=1 for one cycle, then go to IDLE.
- LOCK:
  - `locked`=1.
  - Counter = 0: set `tries`←0 and go to IDLE. Otherwise decrement.
- `go` in any state other than IDLE is dropped, not queued.
- `prog` in any state other than GRANT is dropped.
- `go` and `prog` in the same cycle:
  - In IDLE, only `go` acts.
  - In GRANT, only `prog` acts.
- Counter width is `$clog2(max(GRANT_CYCLES, LOCK_CYCLES))`, minimum 1 bit. It never wraps because it is reloaded on entry to GRANT or LOCK.
- `tries` only increments or clears and never exceeds `MAX_TRIES`.

## Timing
- `go` sampled at edge n:
  - `en`=1 during cycle n+1.
  - `match` is sampled at edge n+2.
  - `grant`, `deny` or `locked` rises at cycle n+3.
- The datapath must present `match` for the current `b`/`v` during the cycle after `en`, i.e. in state WAIT.
- `grant` stays high for exactly `GRANT_CYCLES` cycles. `locked` stays high for exactly `LOCK_CYCLES` cycles. `deny` stays high for exactly 1 cycle.
- After GRANT, DENY or LOCK the block is back in IDLE with `busy`=0, and a new `go` is accepted on that cycle. Minimum request spacing is therefore 4 cycles after a deny.
- `b` holds its value until the next accepted `go`.
- `v` changes only on reset or on an accepted `prog`, visible the cycle after.
- Reset mid-operation in any state applies the full reset values at the next edge. This includes lockout being abandoned and `v` returning to 00.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release. Required: all outputs 0, `v`=00, `busy`=0.
- Correct code with defaults, using a bench match model `match`=(`b`==`v`): `go` with `code`=00 at edge n. Required: `en` high only in cycle n+1; `grant` high cycles n+3..n+12; `tries`=0; `busy` drops at n+13.
- Lockout: three `go` requests with `code`=01, 5 cycles apart.
  - Required: `deny` pulses on the 1st and 2nd attempts, with `tries`=1 then 2.
  - On the 3rd attempt: `locked` high for 50 cycles and `tries`=3.
  - A `go` mid-lock is ignored, giving no `en`.
  - After the lock: IDLE with `tries`=0.
- Programming: grant with `code`=00, then during GRANT pulse `prog` with `code`=10.
  - Required: `v`=10 on the next cycle.
  - A later `go` with 10 produces grant; a `go` with 00 produces deny.
  - `prog` pulsed in IDLE leaves `v` unchanged.
- Dropped requests: `go` during CHECK, WAIT or GRANT produces no additional `en` pulse. `go` and `prog` together in IDLE starts a check and leaves `v` unchanged.
- Reset mid-lock: assert `rst_n`=0 at the 10th lock cycle. Required: the next cycle shows `locked`=0, `tries`=0, IDLE, `v`=00, and an immediate `go` is accepted.

Source files
------------

// File: rtl/access_ctrl.sv
// Sequencing controller for the 2-bit code-compare machine: latches a user
// code, strobes the compare datapath and resolves grant, deny or lockout.
module access_ctrl #(
  parameter int GRANT_CYCLES = 10,
  parameter int LOCK_CYCLES  = 50,
  parameter int MAX_TRIES    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [1:0] code,
  input  logic       prog,
  input  logic       match,
  output logic       en,
  output logic [1:0] b,
  output logic [1:0] v,
  output logic       grant,
  output logic       deny,
  output logic       locked,
  output logic [1:0] tries,
  output logic       busy
);

  localparam int MAX_CYC = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] GRANT_LOAD = CW'(GRANT_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCK_CYCLES - 1);
  localparam logic [2:0]    MAX_T      = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_GRANT,
    S_DENY,
    S_LOCK
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    b_q;
  logic [1:0]    v_q;
  logic [1:0]    tries_q;
  logic          en_q;
  logic          grant_q;
  logic          deny_q;
  logic          locked_q;
  logic          busy_q;

  // Failure count after this attempt, widened so MAX_TRIES=3 cannot overflow.
  logic [2:0] tries_d;
  assign tries_d = {1'b0, tries_q} + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      b_q      <= 2'b00;
      v_q      <= 2'b00;
      tries_q  <= 2'b00;
      en_q     <= 1'b0;
      grant_q  <= 1'b0;
      deny_q   <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            b_q     <= code;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          en_q    <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (match) begin
            tries_q <= 2'b00;
            cnt_q   <= GRANT_LOAD;
            grant_q <= 1'b1;
            state_q <= S_GRANT;
          end else if (tries_d < MAX_T) begin
            tries_q <= tries_d[1:0];
            deny_q  <= 1'b1;
            state_q <= S_DENY;
          end else begin
            tries_q  <= MAX_T[1:0];
            cnt_q    <= LOCK_LOAD;
            locked_q <= 1'b1;
            state_q  <= S_LOCK;
          end
        end
        S_GRANT: begin
          if (prog) begin
            v_q <= code;
          end
          if (cnt_q == '0) begin
            grant_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DENY: begin
          deny_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_LOCK: begin
          if (cnt_q == '0) begin
            tries_q  <= 2'b00;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          en_q     <= 1'b0;
          grant_q  <= 1'b0;
          deny_q   <= 1'b0;
          locked_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign en     = en_q;
  assign b      = b_q;
  assign v      = v_q;
  assign grant  = grant_q;
  assign deny   = deny_q;
  assign locked = locked_q;
  assign tries  = tries_q;
  assign busy   = busy_q;

endmodule
